// File: rtl/spinner_pipe_if.sv
// Handshake bundle for spinner_pipe: an input channel (operand, distance, mode, spin)
// and an output channel (result), each with its own valid/ready pair.
interface spinner_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic [AW-1:0]    amount;
    logic [1:0]       mode;
    logic             spin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;

    // Producer/consumer side (drives requests, takes results)
    modport master (
        output in_valid, din, amount, mode, spin, out_ready,
        input  in_ready, out_valid, dout
    );

    // Shifter side
    modport slave (
        input  in_valid, din, amount, mode, spin, out_ready,
        output in_ready, out_valid, dout
    );
endinterface

// File: rtl/spinner_pipe.sv
// Two-stage rotate/shift pipeline. S1 captures the operand (either din or the last
// completed result when spin=1), distance and mode; a log-depth barrel shifter sits
// between S1 and S2; S2 holds the registered result.
module spinner_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = $clog2(WIDTH)
) (
    input  logic          clock,
    input  logic          reset_n,
    spinner_pipe_if.slave bus
);

    typedef enum logic [1:0] {
        ModeRor = 2'b00,
        ModeRol = 2'b01,
        ModeLsr = 2'b10,
        ModeAsr = 2'b11
    } mode_e;

    // Stage 1
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_op;
    logic [AW-1:0]    r_s1_amt;
    logic [1:0]       r_s1_mode;

    // Stage 2 and the spin feedback value
    logic             r_out_valid;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] r_last;

    logic             w_s2_load;
    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_operand;
    logic [WIDTH-1:0] w_shift;

    // S1 drains into S2 whenever S2 is empty or being consumed on this edge
    assign w_s2_load = r_s1_valid & (~r_out_valid | bus.out_ready);

    // A spin request must see an empty S1 so r_last already holds its predecessor
    assign w_in_ready = (~r_s1_valid | w_s2_load) & ~(bus.spin & r_s1_valid);
    assign w_accept   = bus.in_valid & w_in_ready;
    assign w_operand  = bus.spin ? r_last : bus.din;

    // Barrel shifter: stage s conditionally moves by 2**s under the selected mode
    for (genvar s = 0; s < AW; s++) begin : g_stage
        localparam int unsigned Dist = 1 << s;
        logic [WIDTH-1:0] w_in;
        logic [WIDTH-1:0] w_out;

        if (s == 0) begin : g_first
            assign w_in = r_s1_op;
        end else begin : g_next
            assign w_in = g_stage[s-1].w_out;
        end

        // Apply this stage's distance when its amount bit is set
        always_comb begin
            w_out = w_in;
            if (r_s1_amt[s]) begin
                unique case (mode_e'(r_s1_mode))
                    ModeRor: w_out = {w_in[Dist-1:0], w_in[WIDTH-1:Dist]};
                    ModeRol: w_out = {w_in[WIDTH-Dist-1:0], w_in[WIDTH-1:WIDTH-Dist]};
                    ModeLsr: w_out = {{Dist{1'b0}}, w_in[WIDTH-1:Dist]};
                    ModeAsr: w_out = {{Dist{w_in[WIDTH-1]}}, w_in[WIDTH-1:Dist]};
                    default: w_out = w_in;
                endcase
            end
        end
    end

    assign w_shift = g_stage[AW-1].w_out;

    // S1: load on accept, otherwise empty out when its contents move to S2
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_amt   <= '0;
            r_s1_mode  <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_op    <= w_operand;
            r_s1_amt   <= bus.amount;
            r_s1_mode  <= bus.mode;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // S2: capture shifter output; last result tracks every load, not consumption
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_last      <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_dout      <= w_shift;
            r_last      <= w_shift;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.dout      = r_dout;

endmodule

// File: tb/tb_spinner_pipe.sv
// Directed bench for spinner_pipe (WIDTH=32). Expected results are pushed when a
// request is accepted; a negedge monitor pops and compares every delivered output.
module tb_spinner_pipe;

    logic clock;
    logic reset_n;

    spinner_pipe_if #(.WIDTH(32)) bus ();

    spinner_pipe #(.WIDTH(32)) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    logic [31:0]   exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every consumed output must match the oldest outstanding expectation
    always @(negedge clock) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: got 0x%08h expected none", bus.dout);
            end else begin
                chk("dout", bus.dout, exp_q.pop_front());
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [1:0] m,
                        input logic s, input logic [31:0] exp, output int waits);
        bus.in_valid = 1'b1;
        bus.din      = d;
        bus.amount   = a;
        bus.mode     = m;
        bus.spin     = s;
        waits        = 0;
        @(negedge clock);
        while (!bus.in_ready && waits < 20) begin
            waits++;
            @(negedge clock);
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 for din 0x%08h", d);
        end else begin
            exp_q.push_back(exp);
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.spin     = 1'b0;
    endtask

    int w;
    int w2;

    initial begin
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.din       = '0;
        bus.amount    = '0;
        bus.mode      = '0;
        bus.spin      = 1'b0;
        bus.out_ready = 1'b1;
        #23;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Reset state
        chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset_dout", bus.dout, 32'd0);
        chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Rotate right by 1 with latency check
        send(32'h0000_0001, 5'd1, 2'b00, 1'b0, 32'h8000_0000, w);
        chk("lat_s1_only", {31'b0, bus.out_valid}, 32'd0);
        @(posedge clock);
        #1;
        chk("lat_out_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("lat_dout", bus.dout, 32'h8000_0000);

        // Back-to-back directed vectors, full throughput expected
        send(32'h8000_0001, 5'd4,  2'b01, 1'b0, 32'h0000_0018, w);
        send(32'h8000_0000, 5'd31, 2'b11, 1'b0, 32'hFFFF_FFFF, w);
        chk("tput_wait0", w, 0);
        send(32'h8000_0000, 5'd31, 2'b10, 1'b0, 32'h0000_0001, w);
        chk("tput_wait1", w, 0);
        send(32'h1234_5678, 5'd8,  2'b01, 1'b0, 32'h3456_7812, w);
        chk("tput_wait2", w, 0);
        send(32'h1234_5678, 5'd8,  2'b00, 1'b0, 32'h7812_3456, w);
        send(32'h8000_0000, 5'd1,  2'b11, 1'b0, 32'hC000_0000, w);
        send(32'h0F00_0000, 5'd4,  2'b11, 1'b0, 32'h00F0_0000, w);
        send(32'hDEAD_BEEF, 5'd0,  2'b10, 1'b0, 32'hDEAD_BEEF, w);
        send(32'hDEAD_BEEF, 5'd0,  2'b00, 1'b0, 32'hDEAD_BEEF, w);
        send(32'hDEAD_BEEF, 5'd0,  2'b11, 1'b0, 32'hDEAD_BEEF, w);

        // Spin interlock: one stall cycle, then operates on the previous result
        send(32'h0000_00F0, 5'd4, 2'b00, 1'b0, 32'h0000_000F, w);
        send(32'hFFFF_FFFF, 5'd4, 2'b00, 1'b1, 32'hF000_0000, w);
        chk("spin_stall", w, 1);
        repeat (3) @(posedge clock);
        #1;

        // Back-pressure: two accepted, third held until the consumer returns
        bus.out_ready = 1'b0;
        send(32'd1, 5'd0, 2'b00, 1'b0, 32'd1, w);
        send(32'd2, 5'd0, 2'b00, 1'b0, 32'd2, w);
        chk("bp_second_accept", w, 0);
        chk("bp_dout_hold", bus.dout, 32'd1);
        fork
            send(32'd3, 5'd0, 2'b00, 1'b0, 32'd3, w2);
            begin
                repeat (4) @(posedge clock);
                #1;
                chk("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
                chk("bp_dout_still", bus.dout, 32'd1);
                bus.out_ready = 1'b1;
            end
        join
        chk("bp_stalled", {31'b0, w2 >= 3}, 32'd1);
        repeat (4) @(posedge clock);
        #1;
        chk("bp_drained", exp_q.size(), 0);

        // Reset with both stages full
        bus.out_ready = 1'b0;
        send(32'h0000_0011, 5'd0, 2'b00, 1'b0, 32'h0000_0011, w);
        send(32'h0000_0022, 5'd0, 2'b00, 1'b0, 32'h0000_0022, w);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_dout", bus.dout, 32'd0);
        exp_q.delete();
        #10;
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clock);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clock);
        #1;
        send(32'hAAAA_AAAA, 5'd0, 2'b00, 1'b1, 32'h0000_0000, w);
        chk("rst_spin_wait", w, 0);

        // Drain remaining expectations with a bounded wait
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
        @(negedge clock);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
